// File: rtl/source_char_streamer.sv
// ============================================================================
// Module   : source_char_streamer
// Brief    : Reads assembly text from a synchronous BRAM, strips comments and
//            CRs, collapses whitespace and streams one normalized line at a time.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module source_char_streamer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 2   // must be >= 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic                  stall_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [7:0]            mem_data_in,
  output logic [7:0]            ascii_out,
  output logic                  new_character_out,
  output logic                  valid_data_out,
  output logic                  line_done_out,
  output logic [15:0]           line_number_out,
  output logic                  file_done_out,
  output logic                  error_out,
  output logic                  busy_out
);

  localparam logic [3:0] c_s_idle       = 4'd0;
  localparam logic [3:0] c_s_fetch      = 4'd1;
  localparam logic [3:0] c_s_wait       = 4'd2;
  localparam logic [3:0] c_s_classify   = 4'd3;
  localparam logic [3:0] c_s_emit_space = 4'd4;
  localparam logic [3:0] c_s_emit_char  = 4'd5;
  localparam logic [3:0] c_s_line_term  = 4'd6;
  localparam logic [3:0] c_s_line_end   = 4'd7;
  localparam logic [3:0] c_s_done       = 4'd8;
  localparam logic [3:0] c_s_error      = 4'd9;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]            c_wait_last = 8'(MEM_LATENCY - 1);

  logic [3:0]            r_state;
  logic [3:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wait_cnt;
  logic [7:0]            r_byte;
  logic [15:0]           r_line_number;
  logic                  r_line_nonempty;
  logic                  r_pending_space;
  logic                  r_last_was_comma;
  logic                  r_in_comment;
  logic                  r_eof;
  logic                  r_file_done;
  logic                  r_error;

  logic        w_last;
  logic        w_is_nul;
  logic        w_is_nl;
  logic        w_is_hash;
  logic        w_is_cr;
  logic        w_is_ws;
  logic        w_is_comma;
  logic        w_is_print;
  logic        w_discard;
  logic        w_emit_state;
  logic        w_fetch_state;
  logic        w_accept_start;
  logic [3:0]  w_end_target;
  logic [15:0] w_line_next;

  assign w_last     = (r_addr == c_last_addr);
  assign w_is_nul   = (mem_data_in == 8'h00);
  assign w_is_nl    = (mem_data_in == 8'h0A);
  assign w_is_hash  = (mem_data_in == 8'h23);
  assign w_is_cr    = (mem_data_in == 8'h0D);
  assign w_is_ws    = (mem_data_in == 8'h20) || (mem_data_in == 8'h09);
  assign w_is_comma = (mem_data_in == 8'h2C);
  assign w_is_print = (mem_data_in >= 8'h21) && (mem_data_in <= 8'h7E);

  // Bytes that produce no output and leave the line open
  assign w_discard = r_in_comment || w_is_hash || w_is_cr || w_is_ws;

  assign w_end_target = r_line_nonempty ? c_s_line_term : c_s_done;
  assign w_line_next  = (r_line_number == 16'hFFFF) ? r_line_number
                                                    : r_line_number + 16'd1;

  assign w_accept_start = start_in && ((r_state == c_s_idle) ||
                                       (r_state == c_s_done) ||
                                       (r_state == c_s_error));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_s_idle, c_s_done, c_s_error: begin
        if (start_in) w_next_state = c_s_fetch;
      end
      c_s_fetch: w_next_state = c_s_wait;
      c_s_wait: begin
        if (r_wait_cnt == c_wait_last) w_next_state = c_s_classify;
      end
      c_s_classify: begin
        if (w_is_nul) begin
          w_next_state = w_end_target;
        end else if (w_is_nl) begin
          if (r_line_nonempty) w_next_state = c_s_line_term;
          else                 w_next_state = w_last ? c_s_done : c_s_fetch;
        end else if (w_discard) begin
          w_next_state = w_last ? w_end_target : c_s_fetch;
        end else if (w_is_comma) begin
          w_next_state = c_s_emit_char;
        end else if (w_is_print) begin
          w_next_state = r_pending_space ? c_s_emit_space : c_s_emit_char;
        end else begin
          w_next_state = c_s_error;
        end
      end
      c_s_emit_space: begin
        if (!stall_in) w_next_state = c_s_emit_char;
      end
      c_s_emit_char: begin
        if (!stall_in) w_next_state = r_eof ? c_s_line_term : c_s_fetch;
      end
      c_s_line_term: begin
        if (!stall_in) w_next_state = c_s_line_end;
      end
      c_s_line_end: w_next_state = r_eof ? c_s_done : c_s_fetch;
      default:      w_next_state = c_s_idle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state          <= c_s_idle;
      r_addr           <= '0;
      r_wait_cnt       <= 8'd0;
      r_byte           <= 8'd0;
      r_line_number    <= 16'd0;
      r_line_nonempty  <= 1'b0;
      r_pending_space  <= 1'b0;
      r_last_was_comma <= 1'b0;
      r_in_comment     <= 1'b0;
      r_eof            <= 1'b0;
      r_file_done      <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        c_s_idle, c_s_done, c_s_error: begin
          if (w_accept_start) begin
            r_addr           <= '0;
            r_line_number    <= 16'd1;
            r_line_nonempty  <= 1'b0;
            r_pending_space  <= 1'b0;
            r_last_was_comma <= 1'b0;
            r_in_comment     <= 1'b0;
            r_eof            <= 1'b0;
            r_file_done      <= 1'b0;
            r_error          <= 1'b0;
          end
        end
        c_s_fetch: r_wait_cnt <= 8'd0;
        c_s_wait:  r_wait_cnt <= r_wait_cnt + 8'd1;
        c_s_classify: begin
          r_byte <= mem_data_in;
          r_addr <= r_addr + c_addr_one;
          r_eof  <= r_eof | w_is_nul | w_last;
          if (w_is_nul) begin
            r_eof <= 1'b1;
          end else if (w_is_nl) begin
            r_in_comment <= 1'b0;
            // An empty line never reaches LINE_END, so it is counted here
            if (!r_line_nonempty) r_line_number <= w_line_next;
          end else if (r_in_comment) begin
            r_in_comment <= 1'b1;
          end else if (w_is_hash) begin
            r_in_comment <= 1'b1;
          end else if (w_is_ws) begin
            if (r_line_nonempty && !r_last_was_comma) r_pending_space <= 1'b1;
          end else if (w_is_comma) begin
            r_pending_space <= 1'b0;
          end
        end
        c_s_emit_space: begin
          if (!stall_in) r_pending_space <= 1'b0;
        end
        c_s_emit_char: begin
          if (!stall_in) begin
            r_line_nonempty  <= 1'b1;
            r_pending_space  <= 1'b0;
            r_last_was_comma <= (r_byte == 8'h2C);
          end
        end
        c_s_line_end: begin
          r_line_nonempty  <= 1'b0;
          r_pending_space  <= 1'b0;
          r_last_was_comma <= 1'b0;
          r_in_comment     <= 1'b0;
          if (!r_eof) r_line_number <= w_line_next;
        end
        default: r_wait_cnt <= r_wait_cnt;
      endcase
      if ((r_state != c_s_done) && (w_next_state == c_s_done))
        r_file_done <= 1'b1;
      if ((r_state != c_s_error) && (w_next_state == c_s_error))
        r_error <= 1'b1;
    end
  end

  assign w_emit_state  = (r_state == c_s_emit_space) || (r_state == c_s_emit_char) ||
                         (r_state == c_s_line_term);
  assign w_fetch_state = (r_state == c_s_fetch) || (r_state == c_s_wait) ||
                         (r_state == c_s_classify);

  assign mem_addr_out      = r_addr;
  assign new_character_out = w_emit_state && !stall_in;
  assign ascii_out         = (r_state == c_s_emit_char) ? r_byte :
                             w_emit_state               ? 8'h20  : 8'h00;
  // A line's first character may be stalled; valid rises only when it is taken
  assign valid_data_out    = (w_emit_state && (r_line_nonempty || !stall_in)) ||
                             (w_fetch_state && r_line_nonempty);
  assign line_done_out     = (r_state == c_s_line_end);
  assign line_number_out   = r_line_number;
  assign file_done_out     = r_file_done;
  assign error_out         = r_error;
  assign busy_out          = (r_state != c_s_idle) && (r_state != c_s_done) &&
                             (r_state != c_s_error);

endmodule

`default_nettype wire

// File: tb/tb_source_char_streamer.sv
// ============================================================================
// Module   : tb_source_char_streamer
// Brief    : Directed self-checking bench for source_char_streamer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_source_char_streamer;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 256-byte memory
  logic        start_a = 1'b0, stall_a = 1'b0;
  logic [7:0]  addr_a, data_a, ascii_a, p1_a;
  logic        nc_a, valid_a, ld_a, fd_a, err_a, busy_a;
  logic [15:0] ln_a;
  logic [7:0]  mem_a [256];

  // Instance B: 16-byte memory
  logic        start_b = 1'b0, stall_b = 1'b0;
  logic [3:0]  addr_b;
  logic [7:0]  data_b, ascii_b, p1_b;
  logic        nc_b, valid_b, ld_b, fd_b, err_b, busy_b;
  logic [15:0] ln_b;
  logic [7:0]  mem_b [16];

  source_char_streamer #(.ADDR_WIDTH(8), .MEM_LATENCY(2)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .stall_in(stall_a),
    .mem_addr_out(addr_a), .mem_data_in(data_a), .ascii_out(ascii_a),
    .new_character_out(nc_a), .valid_data_out(valid_a), .line_done_out(ld_a),
    .line_number_out(ln_a), .file_done_out(fd_a), .error_out(err_a), .busy_out(busy_a));

  source_char_streamer #(.ADDR_WIDTH(4), .MEM_LATENCY(2)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .stall_in(stall_b),
    .mem_addr_out(addr_b), .mem_data_in(data_b), .ascii_out(ascii_b),
    .new_character_out(nc_b), .valid_data_out(valid_b), .line_done_out(ld_b),
    .line_number_out(ln_b), .file_done_out(fd_b), .error_out(err_b), .busy_out(busy_b));

  // Two-cycle synchronous BRAM models
  always @(posedge clk) begin
    p1_a   <= mem_a[addr_a];
    data_a <= p1_a;
    p1_b   <= mem_b[addr_b];
    data_b <= p1_b;
  end

  bq_t qa, qb;
  int  la[$], lb[$];
  int  bad_a = 0, bad_b = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (nc_a) begin qa.push_back(ascii_a); if (valid_a !== 1'b1) bad_a++; end
      if (ld_a) begin la.push_back(int'(ln_a)); if (valid_a !== 1'b0) bad_a++; end
      if (nc_b) begin qb.push_back(ascii_b); if (valid_b !== 1'b1) bad_b++; end
      if (ld_b) begin lb.push_back(int'(ln_b)); if (valid_b !== 1'b0) bad_b++; end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_str(input string tag, input bq_t q, input string exp);
    int mism;
    mism = 0;
    chk({tag, "_len"}, q.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      if (i >= q.size() || q[i] !== exp[i]) mism++;
    chk({tag, "_chars"}, mism, 0);
  endtask

  task automatic chk_lines(input string tag, input int q[$], input int exp_line);
    chk({tag, "_ndone"}, q.size(), 1);
    chk({tag, "_lineno"}, (q.size() > 0) ? q[0] : -1, exp_line);
  endtask

  task automatic load_a(input string s);
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem_a[i] = s[i];
  endtask

  task automatic clear_mon();
    qa.delete(); qb.delete(); la.delete(); lb.delete();
    bad_a = 0; bad_b = 0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; tick(1); start_a = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? busy_a : busy_b) === 1'b1 && n < 3000) begin
      tick(1); n++;
    end
    chk({tag, "_timeout"}, (n < 3000) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    int rcount;
    int stall_pulses;
    int stall_ascii_bad;

    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem_b[i] = "a";

    // Reset state
    tick(3);
    chk("rst_addr",  addr_a, 0);
    chk("rst_flags", {nc_a, valid_a, ld_a, fd_a, err_a, busy_a}, 0);
    chk("rst_ascii", ascii_a, 0);
    chk("rst_line",  ln_a, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic line with comma normalization
    load_a("add r1, r2\n");
    clear_mon();
    pulse_start_a();
    chk("t1_busy", busy_a, 1);
    wait_idle("t1", 0);
    chk_str("t1", qa, "add r1,r2 ");
    chk_lines("t1", la, 1);
    chk("t1_done", {fd_a, err_a, busy_a}, 3'b100);
    chk("t1_valid_framing", bad_a, 0);

    // Whitespace-only and comment-only lines, trailing comment at EOF
    load_a("  \t# note\n\nsub r3 r4  # c");
    clear_mon();
    pulse_start_a();
    wait_idle("t2", 0);
    chk_str("t2", qa, "sub r3 r4 ");
    chk_lines("t2", la, 3);
    chk("t2_done", fd_a, 1);

    // Stall while 'r' is pending
    load_a("add r1, r2\n");
    clear_mon();
    pulse_start_a();
    n = 0;
    do begin @(negedge clk); n++; end while (!(nc_a === 1'b1 && ascii_a === 8'h20) && n < 500);
    chk("t3_space_seen", (n < 500) ? 1 : 0, 1);
    @(posedge clk); #1;
    stall_a = 1'b1;
    stall_pulses = 0; stall_ascii_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (nc_a !== 1'b0) stall_pulses++;
      if (ascii_a !== 8'h72) stall_ascii_bad++;
    end
    chk("t3_stall_pulses", stall_pulses, 0);
    chk("t3_stall_ascii", stall_ascii_bad, 0);
    chk("t3_count_at_stall", qa.size(), 4);
    @(posedge clk); #1;
    stall_a = 1'b0;
    wait_idle("t3", 0);
    rcount = 0;
    foreach (qa[i]) if (qa[i] === 8'h72) rcount++;
    chk("t3_r_count", rcount, 2);
    chk_str("t3", qa, "add r1,r2 ");

    // Illegal byte at address 4
    load_a("add ");
    mem_a[4] = 8'h07; mem_a[5] = "x"; mem_a[6] = "y";
    clear_mon();
    pulse_start_a();
    wait_idle("t4", 0);
    chk("t4_err_state", {err_a, busy_a, fd_a, valid_a}, 4'b1000);
    chk("t4_nchars", qa.size(), 3);
    tick(10);
    chk("t4_no_more", qa.size(), 3);
    load_a("add r1, r2\n");
    clear_mon();
    pulse_start_a();
    chk("t4_err_cleared", err_a, 0);
    wait_idle("t4b", 0);
    chk_str("t4b", qa, "add r1,r2 ");

    // Full memory without NUL on the 16-byte instance
    clear_mon();
    start_b = 1'b1; tick(1); start_b = 1'b0;
    wait_idle("t5", 1);
    chk_str("t5", qb, "aaaaaaaaaaaaaaaa ");
    chk_lines("t5", lb, 1);
    chk("t5_done", {fd_b, err_b}, 2'b10);

    // Asynchronous reset mid-line
    load_a("add r1, r2\n");
    clear_mon();
    pulse_start_a();
    n = 0;
    while (qa.size() < 3 && n < 500) begin @(negedge clk); n++; end
    chk("t6_reach_midline", valid_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_addr0",  addr_a, 0);
    chk("t6_outs0",  {nc_a, valid_a, ld_a, fd_a, err_a, busy_a}, 0);
    chk("t6_ascii0", ascii_a, 0);
    chk("t6_line0",  ln_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    clear_mon();
    pulse_start_a();
    chk("t6_restart_addr", addr_a, 0);
    chk("t6_restart_line", ln_a, 1);
    wait_idle("t6", 0);
    chk_str("t6", qa, "add r1,r2 ");
    chk_lines("t6", la, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
